alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_0 / req_valid_1  input  1  requester n has an operation pending.
REQ-005 req_ready_0 / req_ready_1  output  1  requester n's operation is accepted this cycle.
REQ-006 req_a_0 / req_a_1, req_b_0 / req_b_1  input  32  operands A and B.
REQ-007 req_op_0 / req_op_1  input  4  ALU op code.
REQ-008 rsp_valid_0 / rsp_valid_1  output  1  result for requester n is available.
REQ-009 rsp_ready_0 / rsp_ready_1  input  1  requester n consumes the result.
REQ-010 rsp_out  output  32  result, shared by both requesters, qualified by rsp_valid_n.
REQ-011 rsp_flags  output  4  {ZF,CF,OF,SF}.
REQ-012 rsp_err  output  1  the op code was illegal.

Function
REQ-013 The block shall share one ALU instance between two requesters using an FSM with states IDLE, EXEC and RESP.
REQ-014 IDLE behaviour:
- req_ready_n is high combinationally only for the granted requester, and only when its req_valid_n is high.
- On that handshake, latch a, b, op and the grant id, then go to EXEC.
REQ-015 req_ready_0 and req_ready_1 shall be low in EXEC and RESP, and never high together.
REQ-016 EXEC shall last exactly one cycle:
- Drive the ALU from the latched operands.
- Register out and the flags into the result registers.
- Go to RESP.
REQ-017 RESP behaviour:
- Hold rsp_valid_n high for the granted id until rsp_ready_n is high.
- On that handshake, return to IDLE.
- rsp_out, rsp_flags and rsp_err stay stable while rsp_valid_n is high.
REQ-018 Latency: request accepted at edge N -> rsp_valid_n high after edge N+2.
REQ-019 Minimum issue interval is 3 cycles; no new request is accepted in the cycle of the response handshake.
REQ-020 Legal op codes are 0x0-0x8 and 0xD.
REQ-021 Any other op code shall be accepted normally, with result 0, flags 0 and rsp_err=1; legal ops give rsp_err=0.
REQ-022 ZF shall be computed by this block as (registered out == 0), not taken from the ALU.
REQ-023 CF, OF and SF shall be captured from the ALU in EXEC.
REQ-024 Requester-side signals shall be ignored outside IDLE; a dropped req_valid_n needs no special handling.
REQ-025 rsp_valid_n for the non-granted requester shall stay low.

Reset
REQ-026 While rst_n=0:
- FSM goes to IDLE asynchronously.
- Latched operands, results, rsp_* outputs and rsp_err are cleared to 0.
- The round-robin pointer favours requester 0.
REQ-027 A reset asserted in EXEC or RESP shall discard the in-flight operation; no response is delivered after reset.
REQ-028 The ALU instance's rst_n shall be tied to the block's rst_n.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin arbitration.
- When both requesters are valid in IDLE, grant the one not served last.
- The pointer updates only on an accept handshake.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; no pointer register exists.

Structure
REQ-031 Shared package alu_pkg shall hold:
- op code constants (ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=0xD);
- the FSM state enum;
- flag bit-index constants (ZF=3, CF=2, OF=1, SF=0).
REQ-032 The single sub-module shall be the team's existing 32-bit ALU (module ALU); arbitration and FSM stay in alu_arbiter.

Verification
REQ-033 Single op: requester 0 sends ADD a=0xFFFFFFFF, b=1.
- rsp_valid_0 rises 2 cycles after accept.
- rsp_out=0, ZF=1, CF=1, rsp_err=0.
REQ-034 Contention with ALU_ARB_RR_EN, both requesters valid continuously after reset:
- Grants alternate 0,1,0,1.
- Requester 1 gets SUB 5-3 -> rsp_out=2.
REQ-035 Contention without ALU_ARB_RR_EN, both valid continuously: every grant goes to requester 0.
REQ-036 Backpressure: rsp_ready_0 held low 5 cycles.
- rsp_valid_0 and rsp_out stay stable.
- req_ready_1 stays low until the handshake completes.
REQ-037 Illegal op 0xA -> rsp_out=0, rsp_flags=0, rsp_err=1; the next legal op XOR 0xF0^0xFF returns 0x0F with rsp_err=0.
REQ-038 Reset pulsed in RESP:
- rsp_valid_0 drops immediately and no stale response follows.
- The next request is granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_SLTU = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'hD;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
            OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU producing result plus carry/overflow/sign flags.
// Outputs are forced to zero while rst_n is low.
module ALU
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] out,
    output logic              cf,
    output logic              of,
    output logic              sf,
    output logic              illegal
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Result and flag generation; SUB reports borrow in cf.
    always_comb begin
        sum_s   = {1'b0, a} + {1'b0, b};
        diff_s  = {1'b0, a} - {1'b0, b};
        out     = {DATA_W{1'b0}};
        cf      = 1'b0;
        of      = 1'b0;
        illegal = 1'b0;
        if (!rst_n) begin
            out     = {DATA_W{1'b0}};
            illegal = 1'b0;
        end else begin
            illegal = !op_is_legal(op);
            case (op)
                OP_ADD: begin
                    out = sum_s[DATA_W-1:0];
                    cf  = sum_s[DATA_W];
                    of  = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
                end
                OP_SUB: begin
                    out = diff_s[DATA_W-1:0];
                    cf  = diff_s[DATA_W];
                    of  = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
                end
                OP_SLL:  out = a << b[SH_W-1:0];
                OP_SRL:  out = a >> b[SH_W-1:0];
                OP_SRA:  out = $unsigned($signed(a) >>> b[SH_W-1:0]);
                OP_SLT:  out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
                OP_SLTU: out = {{(DATA_W-1){1'b0}}, (a < b)};
                OP_XOR:  out = a ^ b;
                OP_OR:   out = a | b;
                OP_AND:  out = a & b;
                default: out = {DATA_W{1'b0}};
            endcase
        end
        sf = out[DATA_W-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [3:0]        req_op_0,
    input  logic [3:0]        req_op_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_0,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_out,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err
);

    arb_state_t        state_r;
    logic              grant_id_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [3:0]        op_r;
    logic [DATA_W-1:0] rsp_out_r;
    logic [3:0]        rsp_flags_r;
    logic              rsp_err_r;
    logic              rsp_valid_0_r;
    logic              rsp_valid_1_r;

    logic              grant_id_s;
    logic              accept_s;
    logic              rsp_hs_s;
    logic              tie_pick_s;

    logic [DATA_W-1:0] alu_out_s;
    logic              alu_cf_s;
    logic              alu_of_s;
    logic              alu_sf_s;
    logic              alu_illegal_s;

`ifdef ALU_ARB_RR_EN
    logic              prio_r;

    // Next-preferred requester; flips away from whoever was just accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (accept_s) begin
            prio_r <= ~grant_id_s;
        end
    end

    assign tie_pick_s = prio_r;
`else
    assign tie_pick_s = 1'b0;
`endif

    // Grant selection and accept qualification in IDLE.
    always_comb begin
        grant_id_s = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_id_s = tie_pick_s;
        end else if (req_valid_1) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        accept_s = (state_r == IDLE) && (grant_id_s ? req_valid_1 : req_valid_0);
        rsp_hs_s = (state_r == RESP) && (grant_id_r ? rsp_ready_1 : rsp_ready_0);
    end

    assign req_ready_0 = accept_s && !grant_id_s;
    assign req_ready_1 = accept_s &&  grant_id_s;

    ALU #(.DATA_W(DATA_W)) u_alu (
        .rst_n   (rst_n),
        .a       (a_r),
        .b       (b_r),
        .op      (op_r),
        .out     (alu_out_s),
        .cf      (alu_cf_s),
        .of      (alu_of_s),
        .sf      (alu_sf_s),
        .illegal (alu_illegal_s)
    );

    // Main FSM: latch on accept, capture ALU results in EXEC, hold response until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            grant_id_r    <= 1'b0;
            a_r           <= {DATA_W{1'b0}};
            b_r           <= {DATA_W{1'b0}};
            op_r          <= 4'h0;
            rsp_out_r     <= {DATA_W{1'b0}};
            rsp_flags_r   <= 4'h0;
            rsp_err_r     <= 1'b0;
            rsp_valid_0_r <= 1'b0;
            rsp_valid_1_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        grant_id_r <= grant_id_s;
                        a_r        <= grant_id_s ? req_a_1  : req_a_0;
                        b_r        <= grant_id_s ? req_b_1  : req_b_0;
                        op_r       <= grant_id_s ? req_op_1 : req_op_0;
                        state_r    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out_r              <= alu_out_s;
                    // ZF reflects the value being registered; illegal ops report all-zero flags.
                    rsp_flags_r[FLAG_ZF]   <= (alu_out_s == {DATA_W{1'b0}}) && !alu_illegal_s;
                    rsp_flags_r[FLAG_CF]   <= alu_cf_s;
                    rsp_flags_r[FLAG_OF]   <= alu_of_s;
                    rsp_flags_r[FLAG_SF]   <= alu_sf_s;
                    rsp_err_r              <= alu_illegal_s;
                    rsp_valid_0_r          <= !grant_id_r;
                    rsp_valid_1_r          <=  grant_id_r;
                    state_r                <= RESP;
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_0_r <= 1'b0;
                        rsp_valid_1_r <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_0_r <= 1'b0;
                    rsp_valid_1_r <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign rsp_out     = rsp_out_r;
    assign rsp_flags   = rsp_flags_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_valid_0 = rsp_valid_0_r;
    assign rsp_valid_1 = rsp_valid_1_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model and per-cycle monitor.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [3:0]  req_op_0, req_op_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_out;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] out;
        logic [3:0]  flags;
        logic        err;
        int          acc_cycle;
    } exp_t;

    exp_t        q[$];
    logic        grant_log[$];
    logic        model_prio = 1'b0;
    logic [31:0] last_out [2];
    int          last_acc_cycle = 0;

    // Reference semantics of one operation, flags packed {ZF,CF,OF,SF}.
    function automatic exp_t model_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        logic [32:0] wide;
        logic [31:0] r;
        logic        c, o, err;
        r = 32'h0; c = 1'b0; o = 1'b0; err = 1'b0;
        case (op)
            4'h0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32];
                        o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'h8: begin r = a - b; c = (a < b); o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'h1: r = a << b[4:0];
            4'h5: r = a >> b[4:0];
            4'hD: r = $unsigned($signed(a) >>> b[4:0]);
            4'h2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: r = (a < b) ? 32'd1 : 32'd0;
            4'h4: r = a ^ b;
            4'h6: r = a | b;
            4'h7: r = a & b;
            default: err = 1'b1;
        endcase
        e.out   = r;
        e.err   = err;
        e.flags = err ? 4'h0 : {(r == 32'h0), c, o, r[31]};
        e.id    = 1'b0;
        e.acc_cycle = 0;
        return e;
    endfunction

    // Per-cycle monitor: arbitration rule, one-in-flight rule, latency and response contents.
    always @(negedge clk) begin
        exp_t e;
        logic exp_id;
        if (!rst_n) begin
            q.delete();
            model_prio = 1'b0;
        end else begin
            if (req_ready_0 && req_ready_1) check("both_ready", 32'd1, 32'd0);
            if (q.size() != 0) begin
                if (req_ready_0 || req_ready_1) check("ready_while_busy", 32'd1, 32'd0);
            end else if (req_valid_0 || req_valid_1) begin
`ifdef ALU_ARB_RR_EN
                exp_id = (req_valid_0 && req_valid_1) ? model_prio : req_valid_1;
`else
                exp_id = (req_valid_0 && req_valid_1) ? 1'b0 : req_valid_1;
`endif
                check("ready_0_grant", {31'd0, req_ready_0}, {31'd0, !exp_id});
                check("ready_1_grant", {31'd0, req_ready_1}, {31'd0, exp_id});
                e = exp_id ? model_op(req_a_1, req_b_1, req_op_1) : model_op(req_a_0, req_b_0, req_op_0);
                e.id = exp_id;
                e.acc_cycle = cycle;
                q.push_back(e);
                grant_log.push_back(exp_id);
                last_acc_cycle = cycle;
                model_prio = ~exp_id;
            end
            if (q.size() == 0) begin
                check("no_stale_rsp", {31'd0, rsp_valid_0 | rsp_valid_1}, 32'd0);
            end else if (q[0].acc_cycle != cycle) begin
                e = q[0];
                check("rsp_valid_0", {31'd0, rsp_valid_0}, {31'd0, (cycle >= e.acc_cycle + 2) && !e.id});
                check("rsp_valid_1", {31'd0, rsp_valid_1}, {31'd0, (cycle >= e.acc_cycle + 2) &&  e.id});
                if (cycle >= e.acc_cycle + 2) begin
                    check("rsp_out",   rsp_out, e.out);
                    check("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flags});
                    check("rsp_err",   {31'd0, rsp_err}, {31'd0, e.err});
                    if (e.id ? rsp_ready_1 : rsp_ready_0) begin
                        last_out[e.id] = rsp_out;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bit got;
        got = 1'b0;
        if (id) begin req_a_1 = a; req_b_1 = b; req_op_1 = op; req_valid_1 = 1'b1; end
        else    begin req_a_0 = a; req_b_0 = b; req_op_0 = op; req_valid_0 = 1'b1; end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (id ? req_ready_1 : req_ready_0) got = 1'b1;
        end
        if (!got) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (id) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
    endtask

    task automatic wait_rsp(input logic id, output int seen_cycle);
        bit got;
        got = 1'b0;
        seen_cycle = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (id ? rsp_valid_1 : rsp_valid_0) begin got = 1'b1; seen_cycle = cycle; end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        check("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = 32'h0; req_a_1 = 32'h0; req_b_0 = 32'h0; req_b_1 = 32'h0;
        req_op_0 = 4'h0; req_op_1 = 4'h0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
        check("reset_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
        check("reset_rsp_out",     rsp_out, 32'h0);
        check("reset_rsp_flags",   {28'd0, rsp_flags}, 32'h0);
        check("reset_rsp_err",     {31'd0, rsp_err}, 32'h0);
        rst_n = 1'b1;

        // Single ADD with wrap-around.
        issue(1'b0, 32'hFFFF_FFFF, 32'h1, OP_ADD);
        wait_rsp(1'b0, seen);
        check("add_latency", seen - last_acc_cycle, 32'd2);
        check("add_out",   rsp_out, 32'h0);
        check("add_flags", {28'd0, rsp_flags}, 32'hC);
        check("add_err",   {31'd0, rsp_err}, 32'h0);
        drain();

        // Contention from a fresh reset.
        do_reset();
        grant_log.delete();
        req_a_0 = 32'd1; req_b_0 = 32'd2; req_op_0 = OP_ADD; req_valid_0 = 1'b1;
        req_a_1 = 32'd5; req_b_1 = 32'd3; req_op_1 = OP_SUB; req_valid_1 = 1'b1;
        for (int i = 0; i < 100 && grant_log.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        drain();
        check("grant_count", grant_log.size(), 32'd4);
        if (grant_log.size() >= 4) begin
`ifdef ALU_ARB_RR_EN
            check("grant0", {31'd0, grant_log[0]}, 32'd0);
            check("grant1", {31'd0, grant_log[1]}, 32'd1);
            check("grant2", {31'd0, grant_log[2]}, 32'd0);
            check("grant3", {31'd0, grant_log[3]}, 32'd1);
            check("sub_out_req1", last_out[1], 32'd2);
`else
            check("grant0", {31'd0, grant_log[0]}, 32'd0);
            check("grant1", {31'd0, grant_log[1]}, 32'd0);
            check("grant2", {31'd0, grant_log[2]}, 32'd0);
            check("grant3", {31'd0, grant_log[3]}, 32'd0);
            check("add_out_req0", last_out[0], 32'd3);
`endif
        end

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready_0 = 1'b0;
        req_a_1 = 32'hF0; req_b_1 = 32'h0F; req_op_1 = OP_OR;
        issue(1'b0, 32'd7, 32'd8, OP_ADD);
        req_valid_1 = 1'b1;
        wait_rsp(1'b0, seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid_0}, 32'd1);
            check("bp_out",   rsp_out, 32'd15);
            check("bp_ready1", {31'd0, req_ready_1}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready_0 = 1'b1;
        issue(1'b1, 32'hF0, 32'h0F, OP_OR);
        drain();
        check("bp_req1_out", last_out[1], 32'hFF);

        // Illegal op followed by a legal XOR.
        issue(1'b0, 32'h1234, 32'h5678, 4'hA);
        wait_rsp(1'b0, seen);
        check("ill_out",   rsp_out, 32'h0);
        check("ill_flags", {28'd0, rsp_flags}, 32'h0);
        check("ill_err",   {31'd0, rsp_err}, 32'd1);
        drain();
        issue(1'b0, 32'hF0, 32'hFF, OP_XOR);
        wait_rsp(1'b0, seen);
        check("xor_out", rsp_out, 32'h0F);
        check("xor_err", {31'd0, rsp_err}, 32'd0);
        drain();

        // Reset while a response is pending.
        rsp_ready_0 = 1'b0;
        issue(1'b0, 32'd1, 32'd1, OP_ADD);
        wait_rsp(1'b0, seen);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
        check("rst_rsp_out",     rsp_out, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready_0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, rsp_valid_0 | rsp_valid_1}, 32'd0);
        end
        @(posedge clk); #1;
        req_a_0 = 32'd2; req_b_0 = 32'd2; req_op_0 = OP_AND; req_valid_0 = 1'b1;
        req_a_1 = 32'd3; req_b_1 = 32'd3; req_op_1 = OP_AND; req_valid_1 = 1'b1;
        @(negedge clk);
        check("post_rst_grant0", {31'd0, req_ready_0}, 32'd1);
        check("post_rst_grant1", {31'd0, req_ready_1}, 32'd0);
        @(posedge clk); #1;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
